// File: rtl/fpmul_round_stage.sv
// Normalize / round-to-nearest-even / pack stage for the binary32 multiplier.
// Two registered stages with valid/ready flow control on both sides.
module fpmul_round_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [47:0] prod_in,
    input  logic        nan_in,
    input  logic        inf_in,
    input  logic        zero_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        inexact
);

    logic        s1_valid;
    logic        s1_sign;
    logic [9:0]  s1_exp;
    logic [22:0] s1_mant;
    logic        s1_g;
    logic        s1_st;
    logic        s1_nan;
    logic        s1_inf;
    logic        s1_zero;

    logic        s1_en;
    logic        s2_en;

    logic [22:0] n_mant;
    logic        n_g;
    logic        n_st;
    logic [9:0]  n_exp;

    logic        rnd;
    logic [23:0] rnd_sum;
    logic [9:0]  r_exp;
    logic [31:0] nx_result;
    logic        nx_ovf;
    logic        nx_unf;
    logic        nx_inexact;

    assign s2_en    = ~out_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;

    always_comb begin
        n_mant = prod_in[45:23];
        n_g    = prod_in[22];
        n_st   = |prod_in[21:0];
        n_exp  = exp_in;
        if (prod_in[47]) begin
            n_mant = prod_in[46:24];
            n_g    = prod_in[23];
            n_st   = |prod_in[22:0];
            n_exp  = exp_in + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_g     <= 1'b0;
            s1_st    <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (s1_en && in_valid) begin
                s1_sign <= sign_in;
                s1_exp  <= n_exp;
                s1_mant <= n_mant;
                s1_g    <= n_g;
                s1_st   <= n_st;
                s1_nan  <= nan_in;
                s1_inf  <= inf_in;
                s1_zero <= zero_in;
            end
        end
    end

    // A mantissa carry leaves rnd_sum[22:0] at zero, so only the exponent needs bumping.
    always_comb begin
        rnd        = s1_g & (s1_st | s1_mant[0]);
        rnd_sum    = {1'b0, s1_mant} + {23'd0, rnd};
        r_exp      = s1_exp + {9'd0, rnd_sum[23]};
        nx_result  = {s1_sign, r_exp[7:0], rnd_sum[22:0]};
        nx_ovf     = 1'b0;
        nx_unf     = 1'b0;
        nx_inexact = s1_g | s1_st;
        if (s1_nan) begin
            nx_result  = 32'h7FC0_0000;
            nx_inexact = 1'b0;
        end else if (s1_inf) begin
            nx_result  = {s1_sign, 8'hFF, 23'd0};
            nx_inexact = 1'b0;
        end else if (s1_zero) begin
            nx_result  = {s1_sign, 31'd0};
            nx_inexact = 1'b0;
        end else if ($signed(r_exp) >= 10'sd255) begin
            nx_result  = {s1_sign, 8'hFF, 23'd0};
            nx_ovf     = 1'b1;
            nx_inexact = 1'b1;
        end else if ($signed(r_exp) <= 10'sd0) begin
            nx_result  = {s1_sign, 31'd0};
            nx_unf     = 1'b1;
            nx_inexact = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            if (s2_en) out_valid <= s1_valid;
            if (s2_en && s1_valid) begin
                result  <= nx_result;
                ovf     <= nx_ovf;
                unf     <= nx_unf;
                inexact <= nx_inexact;
            end
        end
    end

endmodule

// File: tb/tb_fpmul_round_stage.sv
// Bench for fpmul_round_stage: directed corner vectors, backpressure, reset
// mid-stream and a randomized stream scored against an arithmetic model.
module tb_fpmul_round_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [47:0] prod_in;
    logic        nan_in;
    logic        inf_in;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inexact;

    int checks = 0;
    int failures = 0;

    fpmul_round_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .prod_in(prod_in),
        .nan_in(nan_in), .inf_in(inf_in), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .unf(unf), .inexact(inexact)
    );

    always #5 clk = ~clk;

    // Value-level model: divide the product down to a 24-bit integer
    // significand, round the remainder to nearest-even, renormalize.
    function automatic logic [34:0] ref_model(input logic sgn, input logic [9:0] ex,
                                              input logic [47:0] prod, input logic nan,
                                              input logic inf, input logic zero);
        longint unsigned p, q, r, half;
        int sh;
        int e;
        logic x;
        logic [7:0] e8;
        logic [22:0] m23;
        if (nan)  return {32'h7FC00000, 3'b000};
        if (inf)  return {sgn, 8'hFF, 23'd0, 3'b000};
        if (zero) return {sgn, 31'd0, 3'b000};
        p = longint'(prod);
        sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
        q = p >> sh;
        r = p - (q << sh);
        half = 64'd1 << (sh - 1);
        e = $signed(ex);
        if (sh == 24) e = e + 1;
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        x = (r != 0);
        if (e >= 255) return {sgn, 8'hFF, 23'd0, 3'b101};
        if (e <= 0)   return {sgn, 31'd0, 3'b011};
        e8 = 8'(e);
        m23 = q[22:0];
        return {sgn, e8, m23, 2'b00, x};
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0;
        sign_in = 1'b0;
        exp_in = '0;
        prod_in = '0;
        nan_in = 1'b0;
        inf_in = 1'b0;
        zero_in = 1'b0;
    endtask

    task automatic rand_operands();
        logic [47:0] p;
        int ev;
        p = {16'($urandom), $urandom};
        if ($urandom_range(1) == 1) p[47] = 1'b1;
        else begin
            p[47] = 1'b0;
            p[46] = 1'b1;
        end
        if ($urandom_range(7) == 0) p[22:0] = 23'h400000;
        ev = int'($urandom_range(300)) - 20;
        sign_in = 1'($urandom);
        exp_in = 10'(ev);
        prod_in = p;
        nan_in = ($urandom_range(15) == 0);
        inf_in = ($urandom_range(15) == 0);
        zero_in = ($urandom_range(15) == 0);
    endtask

    // Offers one operand set on an empty pipe, returns the output and the
    // number of cycles from the acceptance cycle to the first out_valid cycle.
    task automatic send_one(input logic sgn, input logic [9:0] ex, input logic [47:0] prod,
                            input logic nan, input logic inf, input logic zero,
                            output logic [34:0] got, output int lat);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        sign_in = sgn;
        exp_in = ex;
        prod_in = prod;
        nan_in = nan;
        inf_in = inf;
        zero_in = zero;
        #1;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        lat = -1;
        got = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = c;
                got = {result, ovf, unf, inexact};
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=00000000", result);
        end
        checks++;
        if ({ovf, unf, inexact} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {ovf, unf, inexact});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [47:0] prods [8];
        logic [9:0]  exps  [8];
        logic [3:0]  ctl   [8];
        logic [34:0] want  [8];
        logic [34:0] got;
        int lat;
        prods = '{48'h900000000000, 48'h400000400000, 48'h400000C00000, 48'h800000000000,
                  48'h400000000000, 48'h7FFFFFC00000, 48'h123456789ABC, 48'h800000000000};
        exps  = '{10'd127, 10'd127, 10'd127, 10'd254, 10'd0, 10'd127, 10'd3, 10'd127};
        // ctl = {sign, nan, inf, zero}
        ctl   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1100, 4'b1010};
        // 0x400000C00000: kept significand is odd at an exact tie, so it rounds up to ...02.
        // 0x7FFFFFC00000: all-ones significand plus a round-up carries into the exponent.
        want  = '{{32'h40100000, 3'b000}, {32'h3F800000, 3'b001}, {32'h3F800002, 3'b001},
                  {32'h7F800000, 3'b101}, {32'h80000000, 3'b011}, {32'h40000000, 3'b001},
                  {32'h7FC00000, 3'b000}, {32'hFF800000, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            send_one(ctl[i][3], exps[i], prods[i], ctl[i][2], ctl[i][1], ctl[i][0], got, lat);
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d exp=2", i, lat);
            end
            checks++;
            if (got[34:3] !== want[i][34:3]) begin
                failures++;
                $display("FAIL directed_result[%0d] got=%h exp=%h", i, got[34:3], want[i][34:3]);
            end
            checks++;
            if (got[2:0] !== want[i][2:0]) begin
                failures++;
                $display("FAIL directed_flags[%0d] got=%b exp=%b", i, got[2:0], want[i][2:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] p [4];
        logic [9:0]  e [4];
        logic [34:0] want [4];
        int idx;
        int bad_hold;
        for (int i = 0; i < 4; i++) begin
            p[i] = {2'b01, 14'($urandom), $urandom};
            e[i] = 10'(100 + i);
            want[i] = ref_model(1'b0, e[i], p[i], 1'b0, 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        idx = 0;
        bad_hold = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            sign_in = 1'b0;
            exp_in = e[idx];
            prod_in = p[idx];
            nan_in = 1'b0;
            inf_in = 1'b0;
            zero_in = 1'b0;
            #1;
            if (out_valid && {result, ovf, unf, inexact} !== want[0]) bad_hold++;
            if (in_ready) idx++;
        end
        checks++;
        if (idx !== 2) begin
            failures++;
            $display("FAIL bp_accepted got=%0d exp=2", idx);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || bad_hold !== 0) begin
            failures++;
            $display("FAIL bp_hold out_valid=%b unstable_cycles=%0d exp valid=1 unstable=0", out_valid, bad_hold);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 4);
            if (idx < 4) begin
                exp_in = e[idx];
                prod_in = p[idx];
            end
            #1;
            checks++;
            if (out_valid !== 1'b1 || {result, ovf, unf, inexact} !== want[c]) begin
                failures++;
                $display("FAIL bp_drain[%0d] valid=%b got=%h exp=%h", c, out_valid,
                         {result, ovf, unf, inexact}, want[c]);
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx !== 4) begin
            failures++;
            $display("FAIL bp_total_accepted got=%0d exp=4", idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        int stale;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            rand_operands();
            nan_in = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
            failures++;
            $display("FAIL midreset_async got valid=%b ready=%b result=%h exp 0 1 00000000",
                     out_valid, in_ready, result);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release_ready got=%b exp=1", in_ready);
        end
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL midreset_stale got=%0d exp=0", stale);
        end
    endtask

    task automatic test_random_stream();
        logic [34:0] q [$];
        logic [34:0] w;
        int n;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            rand_operands();
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected got=%h", {result, ovf, unf, inexact});
                end else begin
                    w = q.pop_front();
                    if ({result, ovf, unf, inexact} !== w) begin
                        failures++;
                        $display("FAIL rand_result cycle=%0d got=%h exp=%h", c,
                                 {result, ovf, unf, inexact}, w);
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(ref_model(sign_in, exp_in, prod_in, nan_in, inf_in, zero_in));
        end
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                w = q.pop_front();
                checks++;
                if ({result, ovf, unf, inexact} !== w) begin
                    failures++;
                    $display("FAIL rand_drain got=%h exp=%h", {result, ovf, unf, inexact}, w);
                end
            end
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rand_leftover got=%0d exp=0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
